pipelined_bitonic_sorter: RTL and testbench

- Fully pipelined 8-lane bitonic sorting network: accepts one 8-element vector per cycle and returns it sorted six cycles later.
- Generalised over element width and signedness, with per-vector ascending/descending selection.
- Valid/ready handshake on both sides; global stall on output back-pressure.
- Sits between the datapath front-end and the median/rank-select blocks, replacing the purely combinational 8-value sorter where timing closure requires registered stages.

---
 rtl/pipelined_bitonic_sorter.sv | 215 +++++++++++++++++++++
 tb/tb_pipelined_bitonic_sorter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_bitonic_sorter.sv
// pipelined_bitonic_sorter
// Eight-lane bitonic sorting network with one register stage per
// compare-exchange level (six stages). It accepts one vector per cycle and
// uses valid/ready handshakes. Output back-pressure stalls every stage at once.
// Optional feature macro: BITONIC_TAG_EN. When it is defined, each lane carries
// a 3-bit tag holding its original lane index. Ties are broken on that tag, and
// the tags are output on out_idx.
module pipelined_bitonic_sorter #(
    parameter int WIDTH  = 16,
    parameter bit SIGNED = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*WIDTH-1:0] in_data,
    input  logic               in_desc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*WIDTH-1:0] out_data,
`ifdef BITONIC_TAG_EN
    output logic [23:0]        out_idx,
`endif
    output logic [2:0]         occupancy
);

    localparam int LANES  = 8;
    localparam int LEVELS = 6;

    typedef logic [WIDTH-1:0] elem_t;
    typedef logic [2:0]       tag_t;

    // Ordering is the only operation on element values. Signedness only
    // decides where MSB-set values fall.
    function automatic logic elem_gt(input elem_t a, input elem_t b);
        if (SIGNED) begin
            return $signed(a) > $signed(b);
        end else begin
            return a > b;
        end
    endfunction

`ifdef BITONIC_TAG_EN
    // Compare key is {data, tag}. Every key is unique, so ties settle by
    // original lane.
    function automatic logic key_gt(input elem_t a, input tag_t ta,
                                    input elem_t b, input tag_t tb);
        return elem_gt(a, b) || ((a == b) && (ta > tb));
    endfunction
`endif

    // lvl_in[s]  : lanes entering level s (level 0 is fed directly from in_data)
    // stage_d[s] : lanes leaving level s, i.e. next state of stage register s
    elem_t lvl_in  [LEVELS][LANES];
    elem_t stage_d [LEVELS][LANES];
    elem_t data_q  [LEVELS][LANES];

    logic [LEVELS-1:0] valid_q;
    logic [LEVELS-1:0] desc_q;
    logic [2:0]        occ_q;
    logic [2:0]        occ_d;

    logic adv;
    logic accept;
    logic emit;

`ifdef BITONIC_TAG_EN
    tag_t tag_in [LEVELS][LANES];
    tag_t tag_d  [LEVELS][LANES];
    tag_t tag_q  [LEVELS][LANES];
`endif

    // The whole pipeline advances together. The final stage is free when it
    // is empty or is being drained this cycle.
    assign out_valid = valid_q[LEVELS-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign accept    = in_valid && adv;
    assign emit      = out_valid && out_ready;
    assign occupancy = occ_q;

    genvar gi, gj;

    // Level 0 takes the raw input lanes. Each lane is tagged with its own index.
    for (gi = 0; gi < LANES; gi++) begin : g_in
        assign lvl_in[0][gi] = in_data[gi*WIDTH +: WIDTH];
`ifdef BITONIC_TAG_EN
        assign tag_in[0][gi] = tag_t'(gi);
`endif
    end

    // Each later level reads the register stage written by the level before it.
    for (gi = 1; gi < LEVELS; gi++) begin : g_link
        for (gj = 0; gj < LANES; gj++) begin : g_lane
            assign lvl_in[gi][gj] = data_q[gi-1][gj];
`ifdef BITONIC_TAG_EN
            assign tag_in[gi][gj] = tag_q[gi-1][gj];
`endif
        end
    end

    // Compare-exchange levels.
    // BLK is the size of the bitonic block being built, and DIST is the
    // comparator span.
    // Levels 0-2 sort lanes 0-3 up and lanes 4-7 down, which yields one
    // bitonic sequence.
    // Levels 3-5 merge that sequence fully ascending.
    // The requested order is never applied inside the network. It is applied
    // only by the output mux.
    for (gi = 0; gi < LEVELS; gi++) begin : g_level
        localparam int BLK  = (gi == 0) ? 2 : ((gi < 3) ? 4 : 8);
        localparam int DIST = (gi == 1 || gi == 4) ? 2 : ((gi == 3) ? 4 : 1);
        for (gj = 0; gj < LANES/2; gj++) begin : g_cmp
            localparam int LO  = (gj / DIST) * 2 * DIST + (gj % DIST);
            localparam int HI  = LO + DIST;
            localparam bit ASC = ((LO & BLK) == 0);
            logic swap;
`ifdef BITONIC_TAG_EN
            assign swap = ASC ?
                key_gt(lvl_in[gi][LO], tag_in[gi][LO], lvl_in[gi][HI], tag_in[gi][HI]) :
                key_gt(lvl_in[gi][HI], tag_in[gi][HI], lvl_in[gi][LO], tag_in[gi][LO]);
            assign tag_d[gi][LO] = swap ? tag_in[gi][HI] : tag_in[gi][LO];
            assign tag_d[gi][HI] = swap ? tag_in[gi][LO] : tag_in[gi][HI];
`else
            assign swap = ASC ? elem_gt(lvl_in[gi][LO], lvl_in[gi][HI]) :
                                elem_gt(lvl_in[gi][HI], lvl_in[gi][LO]);
`endif
            assign stage_d[gi][LO] = swap ? lvl_in[gi][HI] : lvl_in[gi][LO];
            assign stage_d[gi][HI] = swap ? lvl_in[gi][LO] : lvl_in[gi][HI];
        end
    end

    // Stage registers: shift on adv, hold during a stall, clear on reset.
    // Stage 0 data is captured only on a real accept, so data offered outside
    // the handshake never enters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            desc_q  <= '0;
            for (int s = 0; s < LEVELS; s++) begin
                for (int k = 0; k < LANES; k++) begin
                    data_q[s][k] <= '0;
                end
            end
        end else if (adv) begin
            valid_q <= {valid_q[LEVELS-2:0], in_valid};
            desc_q  <= {desc_q[LEVELS-2:0], accept ? in_desc : 1'b0};
            for (int k = 0; k < LANES; k++) begin
                if (accept) begin
                    data_q[0][k] <= stage_d[0][k];
                end
            end
            for (int s = 1; s < LEVELS; s++) begin
                for (int k = 0; k < LANES; k++) begin
                    data_q[s][k] <= stage_d[s][k];
                end
            end
        end
    end

`ifdef BITONIC_TAG_EN
    // Tag registers move in lockstep with the data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LEVELS; s++) begin
                for (int k = 0; k < LANES; k++) begin
                    tag_q[s][k] <= '0;
                end
            end
        end else if (adv) begin
            for (int k = 0; k < LANES; k++) begin
                if (accept) begin
                    tag_q[0][k] <= tag_d[0][k];
                end
            end
            for (int s = 1; s < LEVELS; s++) begin
                for (int k = 0; k < LANES; k++) begin
                    tag_q[s][k] <= tag_d[s][k];
                end
            end
        end
    end
`endif

    // Occupancy: an accept adds one, an emit removes one, and both together
    // cancel out.
    always_comb begin
        occ_d = occ_q;
        if (accept && !emit) begin
            occ_d = occ_q + 3'd1;
        end else if (!accept && emit) begin
            occ_d = occ_q - 3'd1;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Descending output is a pure lane reversal of the ascending final stage.
    for (gi = 0; gi < LANES; gi++) begin : g_out
        assign out_data[gi*WIDTH +: WIDTH] = desc_q[LEVELS-1] ?
            data_q[LEVELS-1][LANES-1-gi] : data_q[LEVELS-1][gi];
`ifdef BITONIC_TAG_EN
        assign out_idx[gi*3 +: 3] = desc_q[LEVELS-1] ?
            tag_q[LEVELS-1][LANES-1-gi] : tag_q[LEVELS-1][gi];
`endif
    end

endmodule

// File: tb/tb_pipelined_bitonic_sorter.sv
// Testbench for pipelined_bitonic_sorter.
// Two instances, one signed and one unsigned, are driven by the same stimulus.
// A scoreboard checks every emitted vector against a plain sort-based model.
// Directed table vectors check exact latency and exact values.
// Hand-written sequences cover stall, bubbles and mid-stream reset.
module tb_pipelined_bitonic_sorter;

    localparam int W = 16;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_desc;
    logic           out_ready;
    logic [8*W-1:0] in_data;
    logic           in_ready_s, out_valid_s, in_ready_u, out_valid_u;
    logic [8*W-1:0] out_data_s, out_data_u;
    logic [2:0]     occ_s, occ_u;
`ifdef BITONIC_TAG_EN
    logic [23:0]    out_idx_s, out_idx_u;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;

    pipelined_bitonic_sorter #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .in_data   (in_data),
        .in_desc   (in_desc),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .out_data  (out_data_s),
`ifdef BITONIC_TAG_EN
        .out_idx   (out_idx_s),
`endif
        .occupancy (occ_s)
    );

    pipelined_bitonic_sorter #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_u),
        .in_data   (in_data),
        .in_desc   (in_desc),
        .out_valid (out_valid_u),
        .out_ready (out_ready),
        .out_data  (out_data_u),
`ifdef BITONIC_TAG_EN
        .out_idx   (out_idx_u),
`endif
        .occupancy (occ_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: a stable sort on the numeric value, followed by a
    // reversal when desc is set.
    function automatic logic [127:0] ref_sort(input logic [127:0] d, input logic desc,
                                              input bit sgn, output logic [23:0] idx);
        int val [8];
        int ord [8];
        int tv;
        int p;
        logic [15:0] e;
        logic [127:0] r;
        for (int k = 0; k < 8; k++) begin
            e = d[k*16 +: 16];
            if (sgn) val[k] = int'($signed(e));
            else     val[k] = int'(e);
            ord[k] = k;
        end
        for (int i = 1; i < 8; i++) begin
            for (int j = i; j > 0 && val[j-1] > val[j]; j--) begin
                tv = val[j]; val[j] = val[j-1]; val[j-1] = tv;
                tv = ord[j]; ord[j] = ord[j-1]; ord[j-1] = tv;
            end
        end
        r = '0;
        idx = '0;
        for (int k = 0; k < 8; k++) begin
            p = desc ? 7 - k : k;
            r[k*16 +: 16] = d[ord[p]*16 +: 16];
            idx[k*3 +: 3] = 3'(ord[p]);
        end
        return r;
    endfunction

    function automatic logic [127:0] pk(input logic [15:0] l0, input logic [15:0] l1,
                                        input logic [15:0] l2, input logic [15:0] l3,
                                        input logic [15:0] l4, input logic [15:0] l5,
                                        input logic [15:0] l6, input logic [15:0] l7);
        return {l7, l6, l5, l4, l3, l2, l1, l0};
    endfunction

    function automatic logic [23:0] pki(input logic [2:0] i0, input logic [2:0] i1,
                                        input logic [2:0] i2, input logic [2:0] i3,
                                        input logic [2:0] i4, input logic [2:0] i5,
                                        input logic [2:0] i6, input logic [2:0] i7);
        return {i7, i6, i5, i4, i3, i2, i1, i0};
    endfunction

    function automatic logic [127:0] rand_vec();
        logic [127:0] r;
        for (int k = 0; k < 8; k++) r[k*16 +: 16] = 16'($urandom);
        if ($urandom_range(0, 2) == 0) r[16 +: 16] = r[80 +: 16];
        return r;
    endfunction

    // Scoreboard: expected results are queued at accept and popped at emit.
    logic [127:0] q_s [$];
    logic [127:0] q_u [$];
    logic [23:0]  qi_s [$];
    logic [23:0]  qi_u [$];

    initial begin : monitor
        logic         prev_stall;
        logic [127:0] prev_out;
        logic [127:0] es;
        logic [127:0] eu;
        logic [23:0]  eis;
        logic [23:0]  eiu;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q_s.delete(); q_u.delete(); qi_s.delete(); qi_u.delete();
                prev_stall = 1'b0;
            end else begin
                chk("occupancy_s", 128'(occ_s), 128'(q_s.size()));
                chk("occupancy_u", 128'(occ_u), 128'(q_s.size()));
                chk("in_ready_rule", 128'(in_ready_s), 128'(!out_valid_s || out_ready));
                chk("in_ready_u", 128'(in_ready_u), 128'(in_ready_s));
                chk("out_valid_u", 128'(out_valid_u), 128'(out_valid_s));
                if (prev_stall) begin
                    chk("stall_valid_held", 128'(out_valid_s), 128'(1));
                    chk("stall_data_held", out_data_s, prev_out);
                end
                if (out_valid_s && out_ready) begin
                    if (q_s.size() == 0) begin
                        chk("spurious_output", 128'(out_valid_s), 128'(0));
                    end else begin
                        es = q_s.pop_front(); eu = q_u.pop_front();
                        eis = qi_s.pop_front(); eiu = qi_u.pop_front();
                        $display("out %0d: signed=%h unsigned=%h", n_out, out_data_s, out_data_u);
                        n_out++;
                        chk("sb_data_signed", out_data_s, es);
                        chk("sb_data_unsigned", out_data_u, eu);
`ifdef BITONIC_TAG_EN
                        chk("sb_idx_signed", 128'(out_idx_s), 128'(eis));
                        chk("sb_idx_unsigned", 128'(out_idx_u), 128'(eiu));
`endif
                    end
                end
                prev_stall = out_valid_s && !out_ready;
                prev_out   = out_data_s;
                if (in_valid && in_ready_s) begin
                    q_s.push_back(ref_sort(in_data, in_desc, 1'b1, eis));
                    q_u.push_back(ref_sort(in_data, in_desc, 1'b0, eiu));
                    qi_s.push_back(eis);
                    qi_u.push_back(eiu);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [127:0] data;
        logic         desc;
        logic [127:0] exp_s;
        logic [127:0] exp_u;
        logic [23:0]  exp_idx;
    } vec_t;

    vec_t tbl [6];

    // Present one table vector alone. Check that nothing appears after five
    // edges and that the exact result appears after six.
    task automatic run_vec(input int i);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = tbl[i].data; in_desc = tbl[i].desc; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = rand_vec(); in_desc = ~tbl[i].desc;
        repeat (4) @(posedge clk);
        #1;
        chk($sformatf("tbl%0d_not_early", i), 128'(out_valid_s), 128'(0));
        @(posedge clk); #1;
        chk($sformatf("tbl%0d_valid", i), 128'(out_valid_s), 128'(1));
        chk($sformatf("tbl%0d_signed", i), out_data_s, tbl[i].exp_s);
        chk($sformatf("tbl%0d_unsigned", i), out_data_u, tbl[i].exp_u);
`ifdef BITONIC_TAG_EN
        chk($sformatf("tbl%0d_idx", i), 128'(out_idx_s), 128'(tbl[i].exp_idx));
`endif
    endtask

    task automatic drain();
        int c;
        c = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while ((q_s.size() != 0 || out_valid_s) && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        chk("drain_empty", 128'(q_s.size()), 128'(0));
    endtask

    initial begin
        logic [127:0] bp_vec [10];
        logic         bp_desc [10];
        logic [127:0] held;
        int sent;
        int stall_left;
        bit seen_first;
        bit stalling;
        int guard;

        tbl[0] = '{pk(16'd5, 16'hFFFD, 16'h7FFF, 16'h8000, 16'd0, 16'd2, 16'd2, 16'hFFFF), 1'b0,
                   pk(16'h8000, 16'hFFFD, 16'hFFFF, 16'd0, 16'd2, 16'd2, 16'd5, 16'h7FFF),
                   pk(16'd0, 16'd2, 16'd2, 16'd5, 16'h7FFF, 16'h8000, 16'hFFFD, 16'hFFFF),
                   pki(3, 1, 7, 4, 5, 6, 0, 2)};
        tbl[1] = '{pk(16'h8000, 16'd1, 16'd0, 16'hFFFF, 16'd3, 16'd3, 16'd7, 16'd2), 1'b1,
                   pk(16'd7, 16'd3, 16'd3, 16'd2, 16'd1, 16'd0, 16'hFFFF, 16'h8000),
                   pk(16'hFFFF, 16'h8000, 16'd7, 16'd3, 16'd3, 16'd2, 16'd1, 16'd0),
                   pki(6, 5, 4, 7, 1, 2, 3, 0)};
        tbl[2] = '{pk(16'd4, 16'd4, 16'd1, 16'd4, 16'd9, 16'd1, 16'd0, 16'd4), 1'b0,
                   pk(16'd0, 16'd1, 16'd1, 16'd4, 16'd4, 16'd4, 16'd4, 16'd9),
                   pk(16'd0, 16'd1, 16'd1, 16'd4, 16'd4, 16'd4, 16'd4, 16'd9),
                   pki(6, 2, 5, 0, 1, 3, 7, 4)};
        tbl[3] = '{pk(16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234), 1'b1,
                   pk(16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234),
                   pk(16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234),
                   pki(7, 6, 5, 4, 3, 2, 1, 0)};
        tbl[4] = '{pk(16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0), 1'b0,
                   pk(16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7),
                   pk(16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7),
                   pki(7, 6, 5, 4, 3, 2, 1, 0)};
        tbl[5] = '{pk(16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000, 16'h0001, 16'h8001, 16'h7FFE, 16'hFFFE), 1'b0,
                   pk(16'h8000, 16'h8001, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h7FFE, 16'h7FFF),
                   pk(16'h0000, 16'h0001, 16'h7FFE, 16'h7FFF, 16'h8000, 16'h8001, 16'hFFFE, 16'hFFFF),
                   pki(1, 5, 7, 2, 3, 4, 6, 0)};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_desc = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 128'(out_valid_s), 128'(0));
        chk("reset_occupancy", 128'(occ_s), 128'(0));
        chk("reset_out_data", out_data_s, 128'(0));
        chk("reset_in_ready", 128'(in_ready_s), 128'(1));
        rst = 1'b0;
        #1;
        chk("release_in_ready", 128'(in_ready_s), 128'(1));

        // Directed vectors.
        for (int i = 0; i < 6; i++) run_vec(i);

        // Back-pressure: 10 vectors with in_valid held high and a 4-cycle stall
        // at the first output.
        for (int i = 0; i < 10; i++) begin
            bp_vec[i]  = rand_vec();
            bp_desc[i] = 1'($urandom_range(0, 1));
        end
        sent = 0; stall_left = 0; seen_first = 1'b0; held = '0;
        for (int cyc = 0; cyc < 200 && !(sent == 10 && q_s.size() == 0); cyc++) begin
            @(posedge clk); #1;
            if (!seen_first && out_valid_s) begin
                seen_first = 1'b1;
                stall_left = 4;
                held = out_data_s;
            end
            stalling  = (stall_left > 0);
            out_ready = !stalling;
            if (stalling) stall_left--;
            in_valid = (sent < 10);
            if (sent < 10) begin
                in_data = bp_vec[sent];
                in_desc = bp_desc[sent];
            end
            #1;
            if (stalling) begin
                chk("bp_in_ready_low", 128'(in_ready_s), 128'(0));
                chk("bp_occupancy_full", 128'(occ_s), 128'(6));
                chk("bp_held_data", out_data_s, held);
            end
            if (in_valid && in_ready_s) sent++;
        end
        chk("bp_all_sent", 128'(sent), 128'(10));
        chk("bp_stall_seen", 128'(seen_first), 128'(1));
        drain();

        // Mixed directions, bubbles of 0-2 cycles and random back-pressure.
        for (int v = 0; v < 20; v++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                out_ready = ($urandom_range(0, 3) != 0);
            end
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = rand_vec(); in_desc = 1'(v % 2);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            guard = 0;
            while (!in_ready_s && guard < 20) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 3) != 0);
                #1;
                guard++;
            end
            if (guard == 20) chk("mixed_accept_timeout", 128'(in_ready_s), 128'(1));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Reset with three vectors in flight.
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = rand_vec(); in_desc = 1'(i % 2);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("midrst_inflight", 128'(occ_s), 128'(3));
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 128'(in_ready_s), 128'(1));
        @(posedge clk); #1;
        chk("midrst_out_valid", 128'(out_valid_s), 128'(0));
        chk("midrst_occupancy", 128'(occ_s), 128'(0));
        chk("midrst_out_data", out_data_s, 128'(0));
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("midrst_release_ready", 128'(in_ready_s), 128'(1));
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("midrst_no_ghost", 128'(out_valid_s), 128'(0));
        end
        chk("final_scoreboard_empty", 128'(q_s.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
